// File: rtl/mic_ifu.sv
// MIC instruction fetch unit: streams bytes from the fetch memory into a small byte queue
// and presents the queue head to the datapath as MBR1 / MBR2.
module mic_ifu #(
    parameter int unsigned QDEPTH = 6
) (
    input  logic        clk_ifu,
    input  logic        reset_ifu_n,
    output logic [31:0] PC_M,
    output logic        Fetch,
    input  logic [7:0]  in_MBR,
    input  logic        pc_load,
    input  logic [31:0] pc_in,
    input  logic        consume1,
    input  logic        consume2,
    output logic [7:0]  MBR1,
    output logic        MBR1_valid,
    output logic [15:0] MBR2,
    output logic        MBR2_valid,
    output logic [31:0] imm_pc,
    output logic        underflow
);

    localparam int unsigned CW = $clog2(QDEPTH + 1);
    localparam int unsigned QW = QDEPTH * 8;

    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_imm_pc;
    logic [QW-1:0] r_q;
    logic [CW-1:0] r_count;
    logic          r_underflow;

    logic [1:0]    w_adv;
    logic          w_uf_set;
    logic [CW-1:0] w_wr_idx;
    logic [QW-1:0] w_q_d;
    logic [CW-1:0] w_count_d;

    assign PC_M  = r_fetch_pc;
    assign Fetch = reset_ifu_n && !pc_load && (r_count < CW'(QDEPTH));

    always_comb begin
        w_adv    = 2'd0;
        w_uf_set = 1'b0;
        if (!pc_load) begin
            if (consume2) begin
                if (r_count >= CW'(2)) w_adv = 2'd2;
                else                   w_uf_set = 1'b1;
            end else if (consume1) begin
                if (r_count >= CW'(1)) w_adv = 2'd1;
                else                   w_uf_set = 1'b1;
            end
        end
    end

    // Bytes above count are always zero, so the fetched byte can simply be OR-ed in.
    always_comb begin
        w_wr_idx  = r_count - CW'(w_adv);
        w_q_d     = r_q >> {w_adv, 3'b000};
        if (Fetch) begin
            w_q_d = w_q_d | ({{(QW - 8){1'b0}}, in_MBR} << {w_wr_idx, 3'b000});
        end
        w_count_d = r_count - CW'(w_adv) + CW'(Fetch);
    end

    always_ff @(posedge clk_ifu or negedge reset_ifu_n) begin
        if (!reset_ifu_n) begin
            r_fetch_pc  <= 32'h0;
            r_imm_pc    <= 32'h0;
            r_q         <= '0;
            r_count     <= '0;
            r_underflow <= 1'b0;
        end else if (pc_load) begin
            r_fetch_pc <= pc_in;
            r_imm_pc   <= pc_in;
            r_q        <= '0;
            r_count    <= '0;
        end else begin
            if (Fetch) r_fetch_pc <= r_fetch_pc + 32'd1;
            r_imm_pc    <= r_imm_pc + 32'(w_adv);
            r_q         <= w_q_d;
            r_count     <= w_count_d;
            r_underflow <= r_underflow | w_uf_set;
        end
    end

    assign MBR1_valid = (r_count >= CW'(1));
    assign MBR2_valid = (r_count >= CW'(2));
    assign MBR1       = MBR1_valid ? r_q[7:0] : 8'h00;
    assign MBR2       = MBR2_valid ? {r_q[7:0], r_q[15:8]} : 16'h0000;
    assign imm_pc     = r_imm_pc;
    assign underflow  = r_underflow;

endmodule

// File: tb/tb_mic_ifu.sv
// Directed bench for mic_ifu: reset fill, streaming consume, consume2 priority, flush,
// underflow and address wrap against a hand-computed fetch memory.
module tb_mic_ifu;

    logic        clk_ifu;
    logic        reset_ifu_n;
    logic [31:0] PC_M;
    logic        Fetch;
    logic [7:0]  in_MBR;
    logic        pc_load;
    logic [31:0] pc_in;
    logic        consume1;
    logic        consume2;
    logic [7:0]  MBR1;
    logic        MBR1_valid;
    logic [15:0] MBR2;
    logic        MBR2_valid;
    logic [31:0] imm_pc;
    logic        underflow;

    int n_pass;
    int n_total;

    mic_ifu #(.QDEPTH(6)) dut (
        .clk_ifu    (clk_ifu),
        .reset_ifu_n(reset_ifu_n),
        .PC_M       (PC_M),
        .Fetch      (Fetch),
        .in_MBR     (in_MBR),
        .pc_load    (pc_load),
        .pc_in      (pc_in),
        .consume1   (consume1),
        .consume2   (consume2),
        .MBR1       (MBR1),
        .MBR1_valid (MBR1_valid),
        .MBR2       (MBR2),
        .MBR2_valid (MBR2_valid),
        .imm_pc     (imm_pc),
        .underflow  (underflow)
    );

    initial clk_ifu = 1'b0;
    always #5 clk_ifu = ~clk_ifu;

    // Addresses 0..5 hold the program bytes; elsewhere the byte is addr[7:0] ^ 0xA5.
    function automatic logic [7:0] mem_byte(input logic [31:0] addr);
        case (addr)
            32'd0:   return 8'h03;
            32'd1:   return 8'h06;
            32'd2:   return 8'h17;
            32'd3:   return 8'h17;
            32'd4:   return 8'h0C;
            32'd5:   return 8'h15;
            default: return addr[7:0] ^ 8'hA5;
        endcase
    endfunction

    always_comb in_MBR = Fetch ? mem_byte(PC_M) : 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_ifu);
        #1;
    endtask

    initial begin
        logic [7:0]  exp_mbr1 [3];
        logic [31:0] exp_pc   [3];
        n_pass      = 0;
        n_total     = 0;
        reset_ifu_n = 1'b0;
        pc_load     = 1'b0;
        pc_in       = 32'h0;
        consume1    = 1'b0;
        consume2    = 1'b0;
        exp_mbr1    = '{8'h06, 8'h17, 8'h17};
        exp_pc      = '{32'd6, 32'd7, 32'd8};

        repeat (2) step();
        check("rst_fetch", 32'(Fetch), 32'd0);
        check("rst_pcm", PC_M, 32'd0);
        check("rst_mbr1", 32'(MBR1), 32'd0);
        check("rst_mbr2", 32'(MBR2), 32'd0);
        check("rst_valids", {30'd0, MBR1_valid, MBR2_valid}, 32'd0);
        check("rst_uf", 32'(underflow), 32'd0);

        // Reset fill
        reset_ifu_n = 1'b1;
        #1;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("fill_fetch%0d", k), 32'(Fetch), 32'd1);
            check($sformatf("fill_pcm%0d", k), PC_M, 32'(k));
            step();
        end
        check("full_fetch", 32'(Fetch), 32'd0);
        check("full_mbr1", 32'(MBR1), 32'h03);
        check("full_mbr2", 32'(MBR2), 32'h0306);
        check("full_imm", imm_pc, 32'd0);

        // Stream consume1
        consume1 = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check($sformatf("c1_mbr1_%0d", k), 32'(MBR1), 32'(exp_mbr1[k]));
            check($sformatf("c1_imm_%0d", k), imm_pc, 32'(k + 1));
            check($sformatf("c1_fetch_%0d", k), 32'(Fetch), 32'd1);
            check($sformatf("c1_pcm_%0d", k), PC_M, exp_pc[k]);
        end

        // consume2 wins over consume1; count 5 -> 4 with a fetch alongside
        consume2 = 1'b1;
        #1;
        check("c2_mbr2_pre", 32'(MBR2), 32'h170C);
        step();
        consume1 = 1'b0;
        consume2 = 1'b0;
        check("c2_imm", imm_pc, 32'd5);
        check("c2_mbr2_post", 32'(MBR2), 32'h15A3);

        // Flush at count 4 with consume1 high
        pc_load  = 1'b1;
        pc_in    = 32'h20;
        consume1 = 1'b1;
        #1;
        check("ld_fetch_low", 32'(Fetch), 32'd0);
        step();
        pc_load  = 1'b0;
        consume1 = 1'b0;
        #1;
        check("ld_valids", {30'd0, MBR1_valid, MBR2_valid}, 32'd0);
        check("ld_imm", imm_pc, 32'h20);
        check("ld_pcm", PC_M, 32'h20);
        check("ld_fetch_high", 32'(Fetch), 32'd1);
        check("ld_uf", 32'(underflow), 32'd0);

        // Underflow: consume2 with one byte queued
        step();
        check("uf_valid1", {30'd0, MBR1_valid, MBR2_valid}, 32'h2);
        check("uf_mbr1", 32'(MBR1), 32'h85);
        consume2 = 1'b1;
        step();
        consume2 = 1'b0;
        check("uf_set", 32'(underflow), 32'd1);
        check("uf_imm", imm_pc, 32'h20);
        check("uf_mbr2", 32'(MBR2), 32'h8584);
        repeat (3) step();
        check("uf_sticky", 32'(underflow), 32'd1);

        // Address wrap
        pc_load = 1'b1;
        pc_in   = 32'hFFFF_FFFF;
        step();
        pc_load = 1'b0;
        #1;
        check("wr_pcm0", PC_M, 32'hFFFF_FFFF);
        check("wr_fetch", 32'(Fetch), 32'd1);
        step();
        check("wr_pcm1", PC_M, 32'h0);
        step();
        check("wr_mbr2", 32'(MBR2), 32'h5A03);
        consume2 = 1'b1;
        step();
        consume2 = 1'b0;
        check("wr_imm", imm_pc, 32'h1);
        check("wr_uf_kept", 32'(underflow), 32'd1);

        // Asynchronous reset mid-cycle clears everything immediately
        #2;
        reset_ifu_n = 1'b0;
        #1;
        check("ar_fetch", 32'(Fetch), 32'd0);
        check("ar_pcm", PC_M, 32'd0);
        check("ar_imm", imm_pc, 32'd0);
        check("ar_uf", 32'(underflow), 32'd0);
        check("ar_valid", 32'(MBR1_valid), 32'd0);
        step();
        reset_ifu_n = 1'b1;
        step();
        check("ar_refill", {24'd0, MBR1}, 32'h03);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
